reg_file_dump: RTL and testbench
================================

# reg_file_dump

Read-side sequencer for the register file: on a start pulse it walks every register through both read ports, two registers per read cycle, and streams (address, data) beats out over a valid/ready interface with a running checksum. It sits beside the register file, owns `readAddress1`/`readAddress2` while busy, and feeds debug/scan-out logic that needs a full architectural-state dump.

## Interface
- `pw`, default 3: register address width; 2^pw registers; pw ≥ 1.
- `dw`, default 8: register data width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  begin a dump; sampled only in IDLE.
- `readAddress1`  out  pw  to register file port 1: always even address `{pairIndex,1'b0}`.
- `readAddress2`  out  pw  to register file port 2: always odd address `{pairIndex,1'b1}`.
- `dataOutput1`  in  dw  combinational read data from port 1.
- `dataOutput2`  in  dw  combinational read data from port 2.
- `outValid`  out  1  beat available.
- `outReady`  in  1  sink accepts beat.
- `outAddress`  out  pw  register address of current beat.
- `outData`  out  dw  register contents of current beat.
- `outLast`  out  1  current beat is register 2^pw−1.
- `busy`  out  1  dump in progress (READ/EMIT_A/EMIT_B).
- `done`  out  1  one-cycle pulse after final beat accepted.
- `checksum`  out  dw  sum mod 2^dw of all accepted beats; held until next start.

## Operation
- States: IDLE, READ, EMIT_A, EMIT_B, DONE. Registers: `pairIndex` (pw−1 bits), `bufA`, `bufB`, `checksum`.
- IDLE: `start`=1 → pairIndex=0, checksum=0, go READ. `start`=0 → stay.
- READ: addresses already stable from `pairIndex`; capture dataOutput1→bufA, dataOutput2→bufB; go EMIT_A unconditionally.
- EMIT_A: outValid=1, outAddress={pairIndex,0}, outData=bufA. On outValid&outReady: checksum+=bufA, go EMIT_B.
- EMIT_B: outValid=1, outAddress={pairIndex,1}, outData=bufB, outLast=1 iff pairIndex all-ones. On handshake: checksum+=bufB; if last → DONE, else pairIndex+1, go READ.
- DONE: done=1, go IDLE.
- Checksum addition truncates to dw bits (carry discarded).
- outValid never deasserts and outAddress/outData never change while outReady=0 (standard valid/ready hold).
- `start` outside IDLE is ignored; no queuing.
- Snapshot semantics: each pair reflects register contents at its READ cycle; writes to a pair after its READ cycle are not reported in this dump.
- Reset (any state, any time): state=IDLE, pairIndex=0, bufA=bufB=0, checksum=0; in-flight dump abandoned, no done pulse.

## Timing
- Reset values: outValid=0, outLast=0, busy=0, done=0, checksum=0, outAddress=0, outData=0, readAddress1=0, readAddress2=1.
- start high in cycle 0 → READ in cycle 1 → first outValid in cycle 2.
- With outReady held 1: 3 cycles per pair; 2^pw=8 → beats in cycles 2,3,5,6,8,9,11,12; done in cycle 13; IDLE in cycle 14.
- Each outReady=0 cycle in EMIT_A/EMIT_B adds exactly one cycle.
- busy high exactly in READ/EMIT_A/EMIT_B cycles; done and busy never both high.
- All outputs are functions of registered state only; no combinational path from outReady or dataOutput* to any output.

## Structure
- Shared package `reg_file_pkg`: state enum typedef (`dumpState_t`), default `pw`/`dw` constants reused by `reg_file`.
- Single module; no sub-module. Bench instantiates `reg_file` and `reg_file_dump` together, read ports wired directly.

## Test plan
- Reset-then-dump: reset, start with outReady=1 → eight beats, addresses 0..7, all data 0x00, outLast only on address 7, checksum=0x00, done in cycle 13.
- Loaded dump: write A5,5A,AA,AB,AC,AD,AE,AF to registers 0..7, start → beats match in order, checksum=0x0A.
- Back-pressure: outReady toggled 1,0,0,1,… → outValid/outAddress/outData held stable during stalls, same eight beats, done delayed by number of stall cycles.
- Ignored start: pulse start during EMIT_B of pair 1 → dump unaffected, exactly eight beats, single done pulse.
- Reset mid-dump: assert reset during EMIT_A of pair 2 → all outputs return to reset values immediately, no done; new start produces full correct dump.
- Snapshot: write 0x11 to register 6 while pair 3 is in EMIT_A (already read) → beat 6 shows old value; write to register 7 before pair 3 READ → beat 7 shows new value.

Source files
------------

// File: rtl/reg_file_pkg.sv
//------------------------------------------------------------------------------
// reg_file_pkg : shared defaults and dump-sequencer state encoding
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package reg_file_pkg;

   localparam int PW_DEFAULT = 3;
   localparam int DW_DEFAULT = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_READ   = 3'd1,
      ST_EMIT_A = 3'd2,
      ST_EMIT_B = 3'd3,
      ST_DONE   = 3'd4
   } dumpState_t;

endpackage

`default_nettype wire

// File: rtl/reg_file.sv
//------------------------------------------------------------------------------
// reg_file : 2^pw x dw register file, one write port, two combinational reads
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg_file
   import reg_file_pkg::*;
#(
   parameter int pw = PW_DEFAULT,
   parameter int dw = DW_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          writeEnable,
   input  logic [pw-1:0] writeAddress,
   input  logic [dw-1:0] writeData,
   input  logic [pw-1:0] readAddress1,
   input  logic [pw-1:0] readAddress2,
   output logic [dw-1:0] dataOutput1,
   output logic [dw-1:0] dataOutput2
);

   logic [dw-1:0] mem [2**pw];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2**pw; i++) begin
            mem[i] <= '0;
         end
      end else if (writeEnable) begin
         mem[writeAddress] <= writeData;
      end
   end

   assign dataOutput1 = mem[readAddress1];
   assign dataOutput2 = mem[readAddress2];

endmodule

`default_nettype wire

// File: rtl/reg_file_dump.sv
//------------------------------------------------------------------------------
// reg_file_dump : walks the register file two registers per read and streams
//                 (address, data) beats over valid/ready with a running sum
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg_file_dump
   import reg_file_pkg::*;
#(
   parameter int pw = PW_DEFAULT,
   parameter int dw = DW_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic [pw-1:0] readAddress1,
   output logic [pw-1:0] readAddress2,
   input  logic [dw-1:0] dataOutput1,
   input  logic [dw-1:0] dataOutput2,
   output logic          outValid,
   input  logic          outReady,
   output logic [pw-1:0] outAddress,
   output logic [dw-1:0] outData,
   output logic          outLast,
   output logic          busy,
   output logic          done,
   output logic [dw-1:0] checksum
);

   localparam int PIW = (pw > 1) ? pw - 1 : 1;

   dumpState_t     state;
   logic [PIW-1:0] pair_index;
   logic [dw-1:0]  buf_a;
   logic [dw-1:0]  buf_b;
   logic [pw-1:0]  addr_even;
   logic [pw-1:0]  addr_odd;
   logic           pair_last;

   // A single-pair file (pw == 1) has no pair index bits at all.
   generate
      if (pw > 1) begin : g_pairs
         assign addr_even = {pair_index, 1'b0};
         assign addr_odd  = {pair_index, 1'b1};
         assign pair_last = &pair_index;
      end else begin : g_single_pair
         assign addr_even = 1'b0;
         assign addr_odd  = 1'b1;
         assign pair_last = 1'b1;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         pair_index <= '0;
         buf_a      <= '0;
         buf_b      <= '0;
         checksum   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  pair_index <= '0;
                  checksum   <= '0;
                  state      <= ST_READ;
               end
            end
            ST_READ: begin
               buf_a <= dataOutput1;
               buf_b <= dataOutput2;
               state <= ST_EMIT_A;
            end
            ST_EMIT_A: begin
               if (outReady) begin
                  checksum <= checksum + buf_a;
                  state    <= ST_EMIT_B;
               end
            end
            ST_EMIT_B: begin
               if (outReady) begin
                  checksum <= checksum + buf_b;
                  if (pair_last) begin
                     state <= ST_DONE;
                  end else begin
                     pair_index <= pair_index + 1'b1;
                     state      <= ST_READ;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Every output decodes registered state only, so beats hold under stalls.
   assign readAddress1 = addr_even;
   assign readAddress2 = addr_odd;
   assign outValid     = (state == ST_EMIT_A) || (state == ST_EMIT_B);
   assign outAddress   = (state == ST_EMIT_B) ? addr_odd :
                         (state == ST_EMIT_A) ? addr_even : '0;
   assign outData      = (state == ST_EMIT_B) ? buf_b :
                         (state == ST_EMIT_A) ? buf_a : '0;
   assign outLast      = (state == ST_EMIT_B) && pair_last;
   assign busy         = (state == ST_READ) || (state == ST_EMIT_A) ||
                         (state == ST_EMIT_B);
   assign done         = (state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_reg_file_dump.sv
//------------------------------------------------------------------------------
// tb_reg_file_dump : register file + dump sequencer against a snapshot model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_file_dump;

   localparam int PW   = 3;
   localparam int DW   = 8;
   localparam int NREG = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rf_rst_n;
   logic          start;
   logic          out_ready;
   logic          we;
   logic [PW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [PW-1:0] ra1;
   logic [PW-1:0] ra2;
   logic [DW-1:0] d1;
   logic [DW-1:0] d2;
   logic          out_valid;
   logic [PW-1:0] out_address;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          done;
   logic [DW-1:0] checksum;

   int            n_checks = 0;
   int            n_pass   = 0;
   logic [DW-1:0] model_mem [NREG];

   always #5 clk = ~clk;

   reg_file #(.pw(PW), .dw(DW)) u_rf (
      .clk          (clk),
      .reset        (rf_rst_n),
      .writeEnable  (we),
      .writeAddress (waddr),
      .writeData    (wdata),
      .readAddress1 (ra1),
      .readAddress2 (ra2),
      .dataOutput1  (d1),
      .dataOutput2  (d2)
   );

   reg_file_dump #(.pw(PW), .dw(DW)) u_dut (
      .clk          (clk),
      .reset        (rst_n),
      .start        (start),
      .readAddress1 (ra1),
      .readAddress2 (ra2),
      .dataOutput1  (d1),
      .dataOutput2  (d2),
      .outValid     (out_valid),
      .outReady     (out_ready),
      .outAddress   (out_address),
      .outData      (out_data),
      .outLast      (out_last),
      .busy         (busy),
      .done         (done),
      .checksum     (checksum)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 0);
      check({tag, "_last"}, 32'(out_last), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_sum"}, 32'(checksum), 0);
      check({tag, "_oaddr"}, 32'(out_address), 0);
      check({tag, "_odata"}, 32'(out_data), 0);
      check({tag, "_ra1"}, 32'(ra1), 0);
      check({tag, "_ra2"}, 32'(ra2), 1);
   endtask

   task automatic write_reg(input logic [PW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      we = 1'b1; waddr = a; wdata = d;
      model_mem[a] = d;
      @(negedge clk);
      we = 1'b0;
   endtask

   // ready_mode: 0 always ready, 1 pattern 1,0,0, 2 random
   // inject: 0 none, 1 start during EMIT_B of pair 1, 2 reset at beat 4, 3 snapshot writes
   task automatic run_dump(input int ready_mode, input int inject);
      logic [DW-1:0] exp_data [NREG];
      logic [DW-1:0] exp_sum;
      logic [PW-1:0] hold_addr;
      logic [DW-1:0] hold_data;
      logic          stalled;
      logic          finished;
      int            cyc;
      int            stalls;
      int            beats;
      int            pat;
      for (int i = 0; i < NREG; i++) exp_data[i] = model_mem[i];
      exp_sum = '0; hold_addr = '0; hold_data = '0;
      stalled = 1'b0; finished = 1'b0; stalls = 0; beats = 0; pat = 0;
      @(negedge clk);
      start = 1'b1; out_ready = 1'b1; we = 1'b0;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!finished && cyc < 400) begin
         we = 1'b0; start = 1'b0;
         check("busy_done_excl", 32'(busy & done), 0);
         if (stalled) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_addr", 32'(out_address), 32'(hold_addr));
            check("hold_data", 32'(out_data), 32'(hold_data));
         end
         if (done) begin
            finished = 1'b1;
            for (int i = 0; i < NREG; i++) exp_sum = exp_sum + exp_data[i];
            check("beats", beats, NREG);
            check("done_cycle", cyc, 13 + stalls);
            check("checksum", 32'(checksum), 32'(exp_sum));
         end else begin
            case (inject)
               1: if (out_valid && out_address == 3'd3) start = 1'b1;
               2: if (out_valid && out_address == 3'd4) begin
                     rst_n = 1'b0;
                     #1;
                     check_reset_outputs("midrst");
                     @(negedge clk);
                     check("midrst_nodone", 32'(done), 0);
                     rst_n = 1'b1;
                     @(negedge clk);
                     check("postrst_done", 32'(done), 0);
                     check("postrst_busy", 32'(busy), 0);
                     return;
                  end
               3: if (out_valid && out_address == 3'd4) begin
                     we = 1'b1; waddr = 3'd7; wdata = 8'h3C;
                     model_mem[7] = 8'h3C; exp_data[7] = 8'h3C;
                  end else if (out_valid && out_address == 3'd6) begin
                     we = 1'b1; waddr = 3'd6; wdata = 8'h11;
                     model_mem[6] = 8'h11;
                  end
               default: ;
            endcase
            case (ready_mode)
               0:       out_ready = 1'b1;
               1:       out_ready = (pat % 3 == 0);
               default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            pat++;
            if (out_valid && out_ready) begin
               check("beat_addr", 32'(out_address), beats);
               check("beat_data", 32'(out_data), 32'(exp_data[beats]));
               check("beat_last", 32'(out_last), 32'(beats == NREG - 1));
               beats++;
            end
            stalled   = out_valid && !out_ready;
            hold_addr = out_address;
            hold_data = out_data;
            if (stalled) stalls++;
            @(negedge clk);
            cyc++;
         end
      end
      out_ready = 1'b1;
      if (!finished) begin
         check("timeout", 0, 1);
      end else begin
         @(negedge clk);
         check("after_done", 32'(done), 0);
         check("after_busy", 32'(busy), 0);
         check("after_valid", 32'(out_valid), 0);
         check("sum_held", 32'(checksum), 32'(exp_sum));
      end
   endtask

   initial begin
      logic [7:0] loaded [NREG];
      loaded = '{8'hA5, 8'h5A, 8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF};
      rst_n = 1'b0; rf_rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
      we = 1'b0; waddr = '0; wdata = '0;
      for (int i = 0; i < NREG; i++) model_mem[i] = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1; rf_rst_n = 1'b1;
      @(negedge clk);

      run_dump(0, 0);

      for (int i = 0; i < NREG; i++) write_reg(3'(i), loaded[i]);
      run_dump(0, 0);
      check("sum_literal", 32'(checksum), 32'h0A);

      run_dump(1, 0);
      run_dump(0, 1);
      run_dump(0, 2);
      run_dump(0, 0);
      run_dump(0, 3);

      for (int r = 0; r < 4; r++) begin
         for (int w = 0; w < 3; w++) begin
            write_reg(3'($urandom_range(0, NREG - 1)), 8'($urandom));
         end
         run_dump(2, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
